fetch_dispatch_ctrl: RTL and testbench
======================================

Name: fetch_dispatch_ctrl

Overview:
Upstream sequencer for the per-opcode execution FSMs (MOV, etc.).
- Fetches the 16-bit instruction at the current PC from synchronous program ROM and holds it in an instruction register.
- Drives it on the shared `instruction` bus and waits for the executing FSM's `done`.
- Then drives a one-cycle all-zero bubble, so every execution FSM returns to its idle state before the next fetch.
- Handles NOP and HALT locally; PC storage and increment live outside this block.

Parameters:
- IW, 16, instruction width
- AW, 8, program address / PC width
- TIMEOUT, 16, EXEC cycles without `done` before an illegal-opcode trap (used only with ILLEGAL_TRAP_EN)
- HALT_OP, 4'hF, opcode that stops the sequencer
- NOP_OP, 4'h0, opcode completed locally, no FSM involved

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = keep fetching, 0 = stop at next instruction boundary
- pc  in  AW  current PC from PC register
- mem_addr  out  AW  ROM address
- mem_rd  out  1  ROM read strobe
- mem_rdata  in  IW  ROM data, valid the cycle after mem_rd
- instruction  out  IW  to all execution FSMs
- done_in  in  1  OR of all execution-FSM done outputs
- pc_skip  out  1  one-cycle PC increment request (NOP/trap)
- busy  out  1  high in any state except IDLE and HALT
- halted  out  1  high in HALT
- illegal  out  1  sticky trap flag

Behaviour:
- State register 3-bit: IDLE=0, FETCH=1, WAIT=2, EXEC=3, BUBBLE=4, HALT=5. Outputs registered or pure state decode; no combinational path from inputs to outputs.
- Reset (rst=0, async): state=IDLE, IR=0, timeout counter=0. All outputs 0: instruction, mem_addr, mem_rd, pc_skip, busy, halted, illegal.
- IDLE: instruction=0. run=1 at edge → FETCH.
- FETCH (1 cycle): mem_addr=pc, mem_rd=1 → WAIT.
- WAIT (1 cycle): mem_rd=0, mem_addr held. At the closing edge IR<=mem_rdata, then branch on opcode IR[15:12]:
  - HALT_OP → HALT
  - NOP_OP → BUBBLE, with pc_skip=1 in that BUBBLE cycle
  - otherwise → EXEC
- EXEC: instruction=IR. done_in=1 at an edge → BUBBLE.
  - The execution FSM performs pcInc itself; the controller never pulses pc_skip for a completed instruction.
- BUBBLE (exactly 1 cycle): instruction=0. run=1 → FETCH, else IDLE.
- HALT: halted=1, instruction=0, busy=0. Exits only via reset; run and done_in are ignored.
- Latency:
  - run sampled at edge 0 gives mem_rd high in cycle 1 and instruction valid from cycle 3.
  - done at edge n gives instruction=0 in cycle n+1 and mem_rd in cycle n+2.
- done_in outside EXEC is ignored.
- run falling mid-instruction: the current instruction completes, then BUBBLE → IDLE.
- pc is sampled only in FETCH; its value in other states is don't-care.
- Back-to-back identical instructions (e.g. two MOVs) are separated by the bubble; this is mandatory, because the execution FSMs re-arm only when the opcode leaves their value.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined:
  - A counter clears on EXEC entry and increments each EXEC cycle without done_in.
  - On the edge where the count reaches TIMEOUT-1 with done_in=0: illegal<=1 (sticky until reset), go to BUBBLE with pc_skip=1.
  - done_in on that same edge wins: normal completion, no trap.
- Undefined:
  - No counter; EXEC waits indefinitely for done_in.
  - illegal is tied to 0.

Decomposition:
- Shared package cpu_pkg: opcode constants (OP_NOP=4'h0, OP_MOV=4'h4, OP_HALT=4'hF), controller state encodings, IW/AW defaults.
- Optional sub-module exec_watchdog: timeout counter with clear/enable/expire; instantiated only under ILLEGAL_TRAP_EN.

Test Plan:
- Reset mid-EXEC, then release: rst=0 while in EXEC with IR=16'h4041 → all outputs 0 immediately (async, not waiting for a clock edge); state IDLE after release.
- MOV flow: run=1, pc=8'h00, ROM[0]=16'h4041 (MOV R1,R1) → mem_rd in cycle 1, instruction=16'h4041 from cycle 3, done_in at cycle 6 → instruction=0 in cycle 7, mem_rd in cycle 8.
- Back-to-back: ROM[0]=ROM[1]=16'h4042 → exactly one cycle of instruction=0 between the two EXEC windows; two done pulses total.
- NOP: ROM[0]=16'h0000 → no EXEC, pc_skip=1 for exactly one cycle (cycle 3), then FETCH.
- HALT: ROM[2]=16'hF000 → halted=1, busy=0, instruction=0; stays halted with run=1 and done_in toggling for 50 cycles.
- Trap (ILLEGAL_TRAP_EN, TIMEOUT=16): ROM[0]=16'h9000, done_in held 0 → illegal=1 and pc_skip=1 in cycle 16 of EXEC, then next fetch; same setup with done_in=1 on cycle 16 → no trap.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode constants, controller state encoding and width defaults shared by the CPU blocks
package cpu_pkg;

    localparam int IW_DEF = 16;
    localparam int AW_DEF = 8;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_EXEC   = 3'd3,
        S_BUBBLE = 3'd4,
        S_HALT   = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/fetch_dispatch_ctrl_if.sv
// rtl/fetch_dispatch_ctrl_if.sv - program ROM, instruction bus and status signals of the fetch/dispatch controller
interface fetch_dispatch_ctrl_if #(
    parameter int IW = cpu_pkg::IW_DEF,
    parameter int AW = cpu_pkg::AW_DEF
);
    logic          run;
    logic [AW-1:0] pc;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [IW-1:0] mem_rdata;
    logic [IW-1:0] instruction;
    logic          done_in;
    logic          pc_skip;
    logic          busy;
    logic          halted;
    logic          illegal;

    modport master (
        input  run, pc, mem_rdata, done_in,
        output mem_addr, mem_rd, instruction, pc_skip, busy, halted, illegal
    );

    modport slave (
        output run, pc, mem_rdata, done_in,
        input  mem_addr, mem_rd, instruction, pc_skip, busy, halted, illegal
    );
endinterface

// File: rtl/exec_watchdog.sv
// rtl/exec_watchdog.sv - EXEC timeout counter; expire flags the cycle where TIMEOUT enabled cycles have elapsed
module exec_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/fetch_dispatch_ctrl.sv
// rtl/fetch_dispatch_ctrl.sv - fetches, dispatches and bubbles instructions for the execution FSMs
// ILLEGAL_TRAP_EN adds an EXEC timeout that sets the sticky illegal flag and skips the instruction.
module fetch_dispatch_ctrl
    import cpu_pkg::*;
#(
    parameter int         IW      = IW_DEF,
    parameter int         AW      = AW_DEF,
    parameter int         TIMEOUT = 16,
    parameter logic [3:0] HALT_OP = OP_HALT,
    parameter logic [3:0] NOP_OP  = OP_NOP
) (
    input logic                 clk,
    input logic                 rst,
    fetch_dispatch_ctrl_if.master bus
);
    ctrl_state_t   state;
    logic [IW-1:0] ir;
    logic [AW-1:0] addr_q;
    logic          rd_q;
    logic          skip_q;
    logic          busy_q;
    logic          halted_q;
    logic [3:0]    rd_op;

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("fetch_dispatch_ctrl: TIMEOUT must be at least 2");
    end

    // Opcode is decoded straight from ROM data so the branch lands on the same edge that loads IR.
    assign rd_op = bus.mem_rdata[IW-1 -: 4];

`ifdef ILLEGAL_TRAP_EN
    logic trap;
    logic illegal_q;

    exec_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == S_WAIT),
        .enable ((state == S_EXEC) && !bus.done_in),
        .expire (trap)
    );

    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            ir       <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            skip_q   <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            rd_q   <= 1'b0;
            skip_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.run) begin
                        state  <= S_FETCH;
                        addr_q <= bus.pc;
                        rd_q   <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (rd_op == HALT_OP) begin
                        state    <= S_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else if (rd_op == NOP_OP) begin
                        state  <= S_BUBBLE;
                        skip_q <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                        ir    <= bus.mem_rdata;
                    end
                end
                S_EXEC: begin
                    // The executing FSM advances the PC itself, so normal completion never pulses pc_skip.
                    if (bus.done_in) begin
                        state <= S_BUBBLE;
                        ir    <= '0;
                    end
`ifdef ILLEGAL_TRAP_EN
                    else if (trap) begin
                        state     <= S_BUBBLE;
                        ir        <= '0;
                        skip_q    <= 1'b1;
                        illegal_q <= 1'b1;
                    end
`endif
                end
                S_BUBBLE: begin
                    if (bus.run) begin
                        state  <= S_FETCH;
                        addr_q <= bus.pc;
                        rd_q   <= 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state  <= S_IDLE;
                    ir     <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr    = addr_q;
    assign bus.mem_rd      = rd_q;
    assign bus.instruction = ir;
    assign bus.pc_skip     = skip_q;
    assign bus.busy        = busy_q;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_fetch_dispatch_ctrl.sv
// tb/tb_fetch_dispatch_ctrl.sv - vector table plus hand sequences for fetch_dispatch_ctrl, with an instruction scoreboard
module tb_fetch_dispatch_ctrl;
    import cpu_pkg::*;

    typedef struct {
        string       name;
        logic [15:0] word;
        int          done_cyc;
        bit          keep_run;
        bit          toggle;
        int          exp_instr;
        int          exp_zero;
        int          exp_skip;
        int          exp_nskip;
        int          exp_rd2;
        int          exp_halt;
        int          exp_idle;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [15:0] rom [256];
    logic [15:0] sb_q [$];
    logic [15:0] prev_instr = '0;
    vec_t        vecs [9];

    fetch_dispatch_ctrl_if #(.IW(16), .AW(8)) bus ();

    fetch_dispatch_ctrl #(.IW(16), .AW(8), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= rom[bus.mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "global timeout");
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        logic [15:0] w;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.mem_rd) begin
            w = rom[bus.mem_addr];
            if (w[15:12] != OP_NOP && w[15:12] != OP_HALT) sb_q.push_back(w);
        end
        if (bus.instruction != 16'h0 && prev_instr == 16'h0) begin
            check("sb_pending", int'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) check("sb_instr", int'(bus.instruction), int'(sb_q.pop_front()));
        end
        prev_instr = bus.instruction;
    endtask

    task automatic apply_reset();
        bus.run     = 1'b0;
        bus.done_in = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst        = 1'b1;
        prev_instr = '0;
        cyc        = 0;
        sb_q.delete();
    endtask

    task automatic run_vec(input vec_t v);
        int first_instr, first_zero, first_skip, nskip, first_rd, rd2, first_halt, idle_at;
        first_instr = 0; first_zero = 0; first_skip = 0; nskip = 0;
        first_rd = 0; rd2 = 0; first_halt = 0; idle_at = 0;
        apply_reset();
        rom[0]      = v.word;
        bus.pc      = 8'h00;
        bus.run     = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (bus.instruction != 16'h0 && first_instr == 0) first_instr = k;
            if (first_instr != 0 && bus.instruction == 16'h0 && first_zero == 0) first_zero = k;
            if (bus.pc_skip) begin
                nskip++;
                if (first_skip == 0) first_skip = k;
            end
            if (bus.mem_rd) begin
                if (first_rd == 0) first_rd = k;
                else if (rd2 == 0) rd2 = k;
            end
            if (bus.halted && first_halt == 0) first_halt = k;
            if (!bus.busy && idle_at == 0) idle_at = k;
            bus.run     = v.keep_run;
            bus.done_in = (k == v.done_cyc) || (v.toggle && k[0]);
        end
        bus.done_in = 1'b0;
        check({v.name, "/rd1"},     first_rd,    1);
        check({v.name, "/instr"},   first_instr, v.exp_instr);
        check({v.name, "/zero"},    first_zero,  v.exp_zero);
        check({v.name, "/skip"},    first_skip,  v.exp_skip);
        check({v.name, "/nskip"},   nskip,       v.exp_nskip);
        check({v.name, "/rd2"},     rd2,         v.exp_rd2);
        check({v.name, "/halt"},    first_halt,  v.exp_halt);
        check({v.name, "/idle"},    idle_at,     v.exp_idle);
        check({v.name, "/sb_left"}, int'(sb_q.size()), 0);
    endtask

    initial begin
        int ndone, wlen, nwin, d1, z1, r1, addr2;

        vecs[0] = '{"mov_flow",       16'h4041, 6, 1'b1, 1'b0, 3, 7, 0, 0, 8, 0, 0};
        vecs[1] = '{"mov_stop",       16'h4041, 6, 1'b0, 1'b0, 3, 7, 0, 0, 0, 0, 8};
        vecs[2] = '{"nop_run",        16'h0000, 0, 1'b1, 1'b0, 0, 0, 3, 4, 4, 0, 0};
        vecs[3] = '{"nop_stop",       16'h0FFF, 0, 1'b0, 1'b0, 0, 0, 3, 1, 0, 0, 4};
        vecs[4] = '{"halt_toggle",    16'hF000, 0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 3, 3};
        vecs[5] = '{"halt_lowbits",   16'hFABC, 0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 3, 3};
        vecs[6] = '{"op7_fast",       16'h7123, 3, 1'b1, 1'b0, 3, 4, 0, 0, 5, 0, 0};
        vecs[7] = '{"opE_early_done", 16'hE001, 2, 1'b0, 1'b0, 3, 0, 0, 0, 0, 0, 0};
        vecs[8] = '{"op1_done5",      16'h1FFF, 5, 1'b0, 1'b0, 3, 6, 0, 0, 0, 0, 7};

        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        bus.run     = 1'b0;
        bus.done_in = 1'b0;
        bus.pc      = 8'h00;

        // asynchronous reset before any clock edge
        #2 rst = 1'b0;
        #1;
        check("rst_instruction", int'(bus.instruction), 0);
        check("rst_mem_addr",    int'(bus.mem_addr),    0);
        check("rst_mem_rd",      int'(bus.mem_rd),      0);
        check("rst_pc_skip",     int'(bus.pc_skip),     0);
        check("rst_busy",        int'(bus.busy),        0);
        check("rst_halted",      int'(bus.halted),      0);
        check("rst_illegal",     int'(bus.illegal),     0);
        @(posedge clk);
        #1 rst = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // reset asserted mid-EXEC takes effect without a clock edge
        apply_reset();
        rom[0]  = 16'h4041;
        bus.pc  = 8'h00;
        bus.run = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        check("mid_exec_instr", int'(bus.instruction), 32'h4041);
        #2 rst = 1'b0;
        #1;
        check("mid_exec_async_rst", int'({bus.instruction, bus.mem_addr, bus.mem_rd, bus.pc_skip,
                                          bus.busy, bus.halted, bus.illegal}), 0);
        bus.run = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("idle_after_release", int'({bus.busy, bus.mem_rd, bus.halted, bus.instruction != 16'h0}), 0);
        end
        bus.run = 1'b1;
        tick();
        check("restart_mem_rd", int'(bus.mem_rd), 1);

        // back-to-back identical MOVs with an external PC that advances on done
        apply_reset();
        rom[0]  = 16'h4042;
        rom[1]  = 16'h4042;
        bus.pc  = 8'h00;
        bus.run = 1'b1;
        ndone = 0; wlen = 0; nwin = 0; d1 = 0; z1 = 0; r1 = 0; addr2 = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.done_in) bus.pc = bus.pc + 8'd1;
            bus.done_in = 1'b0;
            if (bus.instruction != 16'h0) begin
                wlen++;
                if (wlen == 1) nwin++;
            end else begin
                wlen = 0;
            end
            if (d1 != 0 && z1 == 0 && bus.instruction == 16'h0) z1 = k;
            if (d1 != 0 && r1 == 0 && bus.mem_rd) begin
                r1    = k;
                addr2 = int'(bus.mem_addr);
            end
            if (wlen == 2) begin
                bus.done_in = 1'b1;
                ndone++;
                if (d1 == 0) d1 = k;
                if (ndone == 2) bus.run = 1'b0;
            end
        end
        bus.done_in = 1'b0;
        check("b2b_first_done",  d1,      4);
        check("b2b_bubble_len",  z1 - d1, 1);
        check("b2b_refetch",     r1 - d1, 2);
        check("b2b_second_addr", addr2,   1);
        check("b2b_windows",     nwin,    2);
        check("b2b_done_pulses", ndone,   2);
        check("b2b_idle_end",    int'(bus.busy), 0);
        check("b2b_sb_left",     int'(sb_q.size()), 0);

        // HALT ignores run and done_in until reset
        apply_reset();
        rom[2]  = 16'hF000;
        bus.pc  = 8'h02;
        bus.run = 1'b1;
        for (int k = 1; k <= 3; k++) tick();
        check("halt_enter", int'({bus.halted, bus.busy}), 2);
        for (int k = 0; k < 50; k++) begin
            bus.done_in = k[0];
            bus.run     = 1'b1;
            tick();
            check("halt_hold", int'({bus.halted, bus.busy, bus.mem_rd, bus.pc_skip, bus.instruction != 16'h0}), 16);
        end
        bus.done_in = 1'b0;

`ifdef ILLEGAL_TRAP_EN
        // sixteen EXEC cycles without done trap on the closing edge of the sixteenth
        apply_reset();
        rom[0]  = 16'h9000;
        bus.pc  = 8'h00;
        bus.run = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 18) check("trap_pre",     int'({bus.illegal, bus.pc_skip}), 0);
            if (k == 19) check("trap_fire",    int'({bus.illegal, bus.pc_skip, bus.instruction != 16'h0}), 6);
            if (k == 20) check("trap_refetch", int'({bus.mem_rd, bus.pc_skip}), 2);
            if (k == 24) check("trap_sticky",  int'(bus.illegal), 1);
        end
        apply_reset();
        check("trap_cleared", int'(bus.illegal), 0);
        bus.run = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            bus.done_in = (k == 18);
            if (k == 19) check("trap_done_wins", int'({bus.illegal, bus.pc_skip, bus.instruction != 16'h0}), 0);
        end
        bus.done_in = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
